// File: rtl/ascon_permutation_iter.sv
// ---------------------------------------------------------------------------
// ascon_pkg: shared ASCON state type, round-constant table and 5-bit S-box.
//
// ascon_permutation_iter: iterative ASCON permutation, one full round
// (pC -> pS -> pL) per clock, 1..12 rounds selected per request.
//   clock_i   : system clock, rising edge
//   reset_i   : asynchronous active-high reset
//   start_i   : request strobe, sampled only when idle
//   rounds_i  : round count 1..12 (0 -> 1, >12 -> 12), sampled with start_i
//   state_i   : input state, word 0 is x0
//   state_o   : registered state (result holds after done_o)
//   busy_o    : high while rounds execute
//   done_o    : one-cycle pulse when the result is valid on state_o
// ---------------------------------------------------------------------------
package ascon_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned NUM_WORDS  = 5;
    localparam int unsigned MAX_ROUNDS = 12;
    localparam int unsigned RIDX_W     = 4;

    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] state_t;

    localparam logic [7:0] ROUND_CONSTANT [MAX_ROUNDS] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // Index past the table (only reachable after the last round) yields zero.
    function automatic logic [7:0] round_constant(input logic [RIDX_W-1:0] r);
        return (r < RIDX_W'(MAX_ROUNDS)) ? ROUND_CONSTANT[r] : 8'h00;
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    // One complete round: constant addition, substitution, linear diffusion.
    function automatic state_t ascon_round(input state_t s,
                                           input logic [RIDX_W-1:0] r);
        state_t     c;
        state_t     t;
        state_t     l;
        logic [4:0] idx;
        logic [4:0] y;
        c       = s;
        c[2]    = c[2] ^ {56'd0, round_constant(r)};
        t       = '0;
        // Bit-sliced S-box: column i gathered with x0 as MSB.
        for (int i = 0; i < int'(WORD_W); i++) begin
            idx     = {c[0][i], c[1][i], c[2][i], c[3][i], c[4][i]};
            y       = SBOX[idx];
            t[0][i] = y[4];
            t[1][i] = y[3];
            t[2][i] = y[2];
            t[3][i] = y[1];
            t[4][i] = y[0];
        end
        l[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
        l[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
        l[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
        l[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
        l[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        return l;
    endfunction

endpackage

module ascon_permutation_iter
    import ascon_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [3:0]        rounds_i,
    input  state_t            state_i,
    output state_t            state_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic {S_IDLE, S_RUN} fsm_e;

    fsm_e              r_fsm;
    fsm_e              w_fsm_next;
    state_t            r_state;
    state_t            w_state_next;
    state_t            w_round_out;
    logic [RIDX_W-1:0] r_round_idx;
    logic [RIDX_W-1:0] w_round_idx_next;
    logic [RIDX_W-1:0] r_remaining;
    logic [RIDX_W-1:0] w_remaining_next;
    logic [RIDX_W-1:0] w_rounds_eff;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;

    // Saturate illegal round requests into 1..12.
    always_comb begin
        if (rounds_i == 4'd0) begin
            w_rounds_eff = 4'd1;
        end else if (rounds_i > RIDX_W'(MAX_ROUNDS)) begin
            w_rounds_eff = RIDX_W'(MAX_ROUNDS);
        end else begin
            w_rounds_eff = rounds_i;
        end
    end

    // Single-cycle round datapath.
    always_comb begin
        w_round_out = ascon_round(r_state, r_round_idx);
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_fsm_next       = r_fsm;
        w_state_next     = r_state;
        w_round_idx_next = r_round_idx;
        w_remaining_next = r_remaining;
        w_busy_next      = 1'b0;
        w_done_next      = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next     = state_i;
                    w_round_idx_next = RIDX_W'(MAX_ROUNDS) - w_rounds_eff;
                    w_remaining_next = w_rounds_eff;
                    w_busy_next      = 1'b1;
                    w_fsm_next       = S_RUN;
                end
            end
            S_RUN: begin
                w_state_next     = w_round_out;
                w_round_idx_next = r_round_idx + 4'd1;
                w_remaining_next = r_remaining - 4'd1;
                if (r_remaining == 4'd1) begin
                    w_fsm_next  = S_IDLE;
                    w_done_next = 1'b1;
                end else begin
                    w_busy_next = 1'b1;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_round_idx <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_state     <= w_state_next;
            r_round_idx <= w_round_idx_next;
            r_remaining <= w_remaining_next;
            r_busy      <= w_busy_next;
            r_done      <= w_done_next;
        end
    end

    assign state_o = r_state;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Self-checking bench for ascon_permutation_iter: cycle-level reference model
// with a per-cycle compare process, plus directed jobs with literal pins.
module tb_ascon_permutation_iter;

    logic         clock_i  = 1'b0;
    logic         reset_i  = 1'b0;
    logic         start_i  = 1'b0;
    logic [3:0]   rounds_i = 4'd0;
    logic [319:0] state_i  = '0;
    logic [319:0] state_o;
    logic         busy_o;
    logic         done_o;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int dcount   = 0;

    ascon_permutation_iter dut (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .rounds_i (rounds_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clock_i = ~clock_i;

    // ---------------- reference permutation (reference-C style) ----------------
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[63:0];    x1 = s[127:64];  x2 = s[191:128];
        x3 = s[255:192]; x4 = s[319:256];
        x2 = x2 ^ {56'd0, 8'(((15 - r) << 4) | r)};
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
        x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
        x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
        x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
        x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
        logic [319:0] v;
        v = s;
        for (int r = 12 - n; r < 12; r++) v = ref_round(v, r);
        return v;
    endfunction

    function automatic int clamp(input logic [3:0] r);
        if (r == 4'd0) return 1;
        if (r > 4'd12) return 12;
        return int'(r);
    endfunction

    // ---------------- cycle model: busy count, done pulse, visible result ----------------
    int           m_cnt;
    logic         m_done;
    logic [319:0] m_state;
    logic [319:0] m_result;

    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            m_cnt    <= 0;
            m_done   <= 1'b0;
            m_state  <= '0;
            m_result <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (start_i) begin
                m_cnt    <= clamp(rounds_i);
                m_result <= ref_perm(state_i, clamp(rounds_i));
            end
        end else if (m_cnt == 1) begin
            m_cnt   <= 0;
            m_done  <= 1'b1;
            m_state <= m_result;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clock_i) begin
        if (chk_en && !reset_i) begin
            check("busy_o", 320'(busy_o), 320'(m_cnt != 0));
            check("done_o", 320'(done_o), 320'(m_done));
            if (m_cnt == 0) check("state_o_idle", state_o, m_state);
            if (done_o) dcount++;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the done cycle (or on timeout).
    task automatic run_job(input logic [319:0] s, input logic [3:0] r, input bit poke,
                           output logic [319:0] res, output int lat);
        state_i  = s;
        rounds_i = r;
        start_i  = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        lat     = 0;
        while (lat < 20) begin
            if (poke && (lat == 2 || lat == 5)) begin
                start_i = 1'b1;
                state_i = ~s;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clock_i); #1;
            lat++;
            if (done_o) break;
        end
        start_i = 1'b0;
        res     = state_o;
    endtask

    logic [319:0] res, s, s2, init_st;
    int           lat, d0;

    initial begin
        init_st = {256'd0, 64'h80400c0600000000};

        // Reset state.
        #1 reset_i = 1'b1;
        #12;
        check("reset_state", state_o, '0);
        check("reset_busy", 320'(busy_o), '0);
        check("reset_done", 320'(done_o), '0);
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        chk_en  = 1'b1;

        // Model pin: one round on the zero state, hand-computed x0.
        res = ref_perm('0, 1);
        check("model_p1_x0", 320'(res[63:0]), 320'(64'h000964B00000004B));

        // One round on the zero state.
        run_job('0, 4'd1, 1'b0, res, lat);
        check("p1_latency", 320'(lat + 1), 320'd2);
        check("p1_x0", 320'(res[63:0]),    320'(64'h000964B00000004B));
        check("p1_x1", 320'(res[127:64]),  320'(64'h0000000096000213));
        check("p1_x2", 320'(res[191:128]), 320'(64'h53FFFFFFFFFFFF90));
        check("p1_x3", 320'(res[255:192]), 320'(64'h12E580000000004B));
        check("p1_x4", 320'(res[319:256]), 320'd0);

        // p12 / p6 on the ASCON-128 init state and random states.
        run_job(init_st, 4'd12, 1'b0, res, lat);
        check("init_p12", res, ref_perm(init_st, 12));
        check("init_p12_latency", 320'(lat + 1), 320'd13);
        run_job(init_st, 4'd6, 1'b0, res, lat);
        check("init_p6", res, ref_perm(init_st, 6));
        check("init_p6_latency", 320'(lat + 1), 320'd7);
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
            run_job(s, 4'd12, 1'b0, res, lat);
            check("rand_p12", res, ref_perm(s, 12));
            check("rand_p12_latency", 320'(lat + 1), 320'd13);
            run_job(s, 4'd6, 1'b0, res, lat);
            check("rand_p6", res, ref_perm(s, 6));
            check("rand_p6_latency", 320'(lat + 1), 320'd7);
        end

        // Starts during RUN are ignored.
        @(posedge clock_i); #1;
        for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
        d0 = dcount;
        run_job(s, 4'd12, 1'b1, res, lat);
        check("ignored_start_result", res, ref_perm(s, 12));
        check("ignored_start_latency", 320'(lat + 1), 320'd13);
        @(posedge clock_i); #1;
        check("ignored_start_one_done", 320'(dcount - d0), 320'd1);

        // Back-to-back: second start issued in the done cycle.
        for (int w = 0; w < 10; w++) s[32*w +: 32] = $urandom;
        for (int w = 0; w < 10; w++) s2[32*w +: 32] = $urandom;
        run_job(s, 4'd6, 1'b0, res, lat);
        check("b2b_first", res, ref_perm(s, 6));
        run_job(s2, 4'd12, 1'b0, res, lat);
        check("b2b_second", res, ref_perm(s2, 12));
        check("b2b_second_latency", 320'(lat + 1), 320'd13);

        // Clamping of illegal round counts.
        run_job(s, 4'd0, 1'b0, res, lat);
        check("clamp0_result", res, ref_perm(s, 1));
        check("clamp0_latency", 320'(lat + 1), 320'd2);
        run_job(s, 4'd15, 1'b0, res, lat);
        check("clamp15_result", res, ref_perm(s, 12));
        check("clamp15_latency", 320'(lat + 1), 320'd13);

        // Asynchronous reset mid-run, after E3 of a 12-round job.
        @(posedge clock_i); #1;
        state_i  = s2;
        rounds_i = 4'd12;
        start_i  = 1'b1;
        @(posedge clock_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #3 reset_i = 1'b1;
        #1;
        check("midrun_reset_state", state_o, '0);
        check("midrun_reset_busy", 320'(busy_o), '0);
        check("midrun_reset_done", 320'(done_o), '0);
        d0 = dcount;
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        repeat (16) @(posedge clock_i);
        #1;
        check("midrun_no_done", 320'(dcount - d0), 320'd0);
        check("midrun_state_zero", state_o, '0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
